// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Types and constants shared by the two-master serial bus arbiter.
//   arb_state_t : arbiter FSM states
//   M0 / M1     : owner encodings stored in the owner / last registers
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANTED    = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m_if
// Signal bundle for the two-master arbiter: master-side requests and
// responses, the shared bit-serial slave port, and arbiter status.
// Modports:
//   arb    : the arbiter itself
//   master : the environment driving M0/M1
//   slave  : the shared slave port
// -----------------------------------------------------------------------------
interface bus_arbiter_2m_if;

    // Master side
    logic m0_breq,        m1_breq;
    logic m0_bgrant,      m1_bgrant;
    logic m0_mode,        m1_mode;
    logic m0_wr_bus,      m1_wr_bus;
    logic m0_valid,       m1_valid;
    logic m0_ready,       m1_ready;
    logic m0_rd_bus,      m1_rd_bus;
    logic m0_slave_ready, m1_slave_ready;
    logic m0_slave_valid, m1_slave_valid;

    // Slave side
    logic s_mode, s_wr_bus, s_master_valid, s_master_ready;
    logic s_rd_bus, s_slave_ready, s_slave_valid;

    // Status
    logic bus_busy, timeout_err;

    modport arb (
        input  m0_breq, m1_breq, m0_mode, m1_mode, m0_wr_bus, m1_wr_bus,
               m0_valid, m1_valid, m0_ready, m1_ready,
               s_rd_bus, s_slave_ready, s_slave_valid,
        output m0_bgrant, m1_bgrant, m0_rd_bus, m1_rd_bus,
               m0_slave_ready, m1_slave_ready, m0_slave_valid, m1_slave_valid,
               s_mode, s_wr_bus, s_master_valid, s_master_ready,
               bus_busy, timeout_err
    );

    modport master (
        output m0_breq, m1_breq, m0_mode, m1_mode, m0_wr_bus, m1_wr_bus,
               m0_valid, m1_valid, m0_ready, m1_ready,
        input  m0_bgrant, m1_bgrant, m0_rd_bus, m1_rd_bus,
               m0_slave_ready, m1_slave_ready, m0_slave_valid, m1_slave_valid,
               bus_busy, timeout_err
    );

    modport slave (
        input  s_mode, s_wr_bus, s_master_valid, s_master_ready,
        output s_rd_bus, s_slave_ready, s_slave_valid
    );

endinterface

// File: rtl/bus_arbiter_2m_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Counts consecutive idle bus cycles while a master owns the bus and flags
// the cycle in which the TIMEOUT-th idle cycle occurs. TIMEOUT = 0 disables.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   i_count_en  : high while the bus is granted; low clears the counter
//   i_bus_idle  : no owner or slave handshake activity this cycle
//   o_expire    : this cycle completes TIMEOUT consecutive idle cycles
// -----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_count_en,
    input  logic i_bus_idle,
    output logic o_expire
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] r_idle_cnt;

    // Cleared outside GRANTED, so every new grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idle_cnt <= '0;
        end else if (!i_count_en || !i_bus_idle) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != CNT_MAX) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // The current idle cycle is the last one allowed: fire now so the grant
    // drops in the following cycle.
    assign o_expire = WD_EN && i_count_en && i_bus_idle && (r_idle_cnt == CNT_LAST);

endmodule

// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
// Two-master arbiter for the bit-serial system bus. Grants the shared slave
// port with round-robin priority on ties, routes the owner's signals to the
// slave and the slave's responses back to the owner, and reclaims the bus
// through a watchdog when the owner stalls.
// Ports:
//   clk   : clock
//   rstn  : synchronous active-low reset
//   bus   : bus_arbiter_2m_if.arb (requests, grants, slave port, status)
// -----------------------------------------------------------------------------
module bus_arbiter_2m
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rstn,
    bus_arbiter_2m_if.arb bus
);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last;
    logic       r_timeout_err;

    logic w_granted;
    logic w_m0_sel;
    logic w_m1_sel;
    logic w_own_breq;
    logic w_own_valid;
    logic w_own_ready;
    logic w_bus_idle;
    logic w_expire;
    logic w_pick;

    assign w_granted   = (r_state == GRANTED);
    assign w_m0_sel    = w_granted && (r_owner == M0);
    assign w_m1_sel    = w_granted && (r_owner == M1);
    assign w_own_breq  = (r_owner == M1) ? bus.m1_breq  : bus.m0_breq;
    assign w_own_valid = (r_owner == M1) ? bus.m1_valid : bus.m0_valid;
    assign w_own_ready = (r_owner == M1) ? bus.m1_ready : bus.m0_ready;
    assign w_bus_idle  = ~(w_own_valid | w_own_ready | bus.s_slave_ready | bus.s_slave_valid);

    // On a tie the master not served last wins.
    always_comb begin
        w_pick = M0;
        if (bus.m0_breq && bus.m1_breq) begin
            w_pick = ~r_last;
        end else if (bus.m1_breq) begin
            w_pick = M1;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rstn       (rstn),
        .i_count_en (w_granted),
        .i_bus_idle (w_bus_idle),
        .o_expire   (w_expire)
    );

    // A breq drop takes precedence over expiry so a voluntary release never
    // reports a timeout.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_owner       <= M0;
            r_last        <= M1;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.m0_breq || bus.m1_breq) begin
                        r_owner <= w_pick;
                        r_state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!w_own_breq) begin
                        r_state <= TURNAROUND;
                        r_last  <= r_owner;
                    end else if (w_expire) begin
                        r_state       <= TURNAROUND;
                        r_last        <= r_owner;
                        r_timeout_err <= 1'b1;
                    end
                end
                TURNAROUND: r_state <= IDLE;
                default:    r_state <= IDLE;
            endcase
        end
    end

    assign bus.m0_bgrant      = w_m0_sel;
    assign bus.m1_bgrant      = w_m1_sel;
    assign bus.bus_busy       = w_granted;
    assign bus.timeout_err    = r_timeout_err;

    // Owner to slave; forced low outside GRANTED so TURNAROUND parks the slave.
    assign bus.s_mode         = (w_m0_sel & bus.m0_mode)   | (w_m1_sel & bus.m1_mode);
    assign bus.s_wr_bus       = (w_m0_sel & bus.m0_wr_bus) | (w_m1_sel & bus.m1_wr_bus);
    assign bus.s_master_valid = (w_m0_sel & bus.m0_valid)  | (w_m1_sel & bus.m1_valid);
    assign bus.s_master_ready = (w_m0_sel & bus.m0_ready)  | (w_m1_sel & bus.m1_ready);

    // Slave to owner only.
    assign bus.m0_rd_bus      = w_m0_sel & bus.s_rd_bus;
    assign bus.m0_slave_ready = w_m0_sel & bus.s_slave_ready;
    assign bus.m0_slave_valid = w_m0_sel & bus.s_slave_valid;
    assign bus.m1_rd_bus      = w_m1_sel & bus.s_rd_bus;
    assign bus.m1_slave_ready = w_m1_sel & bus.s_slave_ready;
    assign bus.m1_slave_valid = w_m1_sel & bus.s_slave_valid;

endmodule

// File: doc/bus_arbiter_2m.md
# bus_arbiter_2m

Two-master arbiter for the serial system bus. Shares one bit-serial slave port between masters M0 and M1 with registered grants and round-robin priority. Routes the owner's request signals to the slave and the slave's responses back to the owner. A watchdog reclaims the bus from an owner that stalls.

## Interface
- TIMEOUT, 64: consecutive idle cycles in GRANTED before forced release; 0 disables the watchdog.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- m0_breq, m1_breq  in  1  bus request; held high for the whole transaction sequence.
- m0_bgrant, m1_bgrant  out  1  registered grant.
- mX_mode, mX_wr_bus, mX_valid, mX_ready  in  1 each  master-side bus signals (X = 0, 1).
- mX_rd_bus, mX_slave_ready, mX_slave_valid  out  1 each  slave responses returned to master X.
- s_mode, s_wr_bus, s_master_valid, s_master_ready  out  1 each  to slave port.
- s_rd_bus, s_slave_ready, s_slave_valid  in  1 each  from slave port.
- bus_busy  out  1  state is GRANTED.
- timeout_err  out  1  one-cycle pulse on forced release.

## Operation
- State machine, registered: IDLE, GRANTED, TURNAROUND.
- Registers:
  - owner: 1 bit.
  - last: 1 bit, last owner served.
  - idle_cnt: $clog2(TIMEOUT+1) bits.
- IDLE:
  - One request → grant that master.
  - Both requesting → grant !last.
  - Set owner. Clear idle_cnt. Go to GRANTED.
  - No request → stay in IDLE.
- GRANTED:
  - mX_bgrant = (owner==X); all other grants 0.
  - Owner's breq low → TURNAROUND; last ← owner.
  - Else, if TIMEOUT≠0 and idle_cnt==TIMEOUT-1 with the bus idle this cycle → TURNAROUND; last ← owner; timeout_err pulses next cycle.
- TURNAROUND:
  - One cycle with all grants low and s_master_valid=0, so the slave returns to its IDLE.
  - Then → IDLE unconditionally.
- Bus idle is defined as: owner valid, owner ready, s_slave_ready and s_slave_valid all 0.
  - Bus idle → idle_cnt++ (saturating).
  - Any of them high → idle_cnt ← 0.
  - idle_cnt counts only in GRANTED.
- Muxing is combinational on registered state and owner:
  - GRANTED: s_* = owner's signals. Owner's mX_rd_bus/slave_ready/slave_valid = slave inputs.
  - Non-owner, and all masters outside GRANTED: mX_slave_ready = mX_slave_valid = mX_rd_bus = 0.
  - Outside GRANTED: s_mode = s_wr_bus = s_master_valid = s_master_ready = 0.
- Requests from the non-owner are ignored until IDLE; they are not queued.
- A master that drops breq outside GRANTED has no effect.
- Forced-release master may be re-granted in a later IDLE if it is the only requester.

## Timing
- Reset:
  - State IDLE, owner=0, last=1 (M0 wins the first tie), idle_cnt=0.
  - All bgrant=0, bus_busy=0, timeout_err=0, all s_* and mX_* outputs 0.
  - Reset mid-transaction drops the grant the next cycle with no TURNAROUND; the slave must be reset by the same rstn.
- Grant latency: breq sampled high in IDLE at cycle N → bgrant high in cycle N+1. The master may drive valid in N+1.
- Release: breq low in cycle M (GRANTED) → bgrant low from M+1 (TURNAROUND), IDLE at M+2, earliest new grant at M+3.
- Pass-through has zero-cycle latency in both directions while GRANTED.
- Timeout: TIMEOUT consecutive idle cycles C..C+TIMEOUT-1 in GRANTED → grant low at C+TIMEOUT; timeout_err=1 in cycle C+TIMEOUT only.
- Breq drop and timeout in the same cycle → normal release, timeout_err stays 0.

## Structure
- Shared package bus_pkg: arb_state_t enum {IDLE, GRANTED, TURNAROUND}; owner constants M0=1'b0, M1=1'b1.
- Sub-module arb_watchdog: idle_cnt, saturation and expiry compare, parameterised by TIMEOUT.
- Top module holds the FSM, round-robin pick and muxes.

## Test plan
- M0 only: breq at cycle 2 → m0_bgrant=1 from cycle 3. A 16+8-bit write to address 0x0005 with data 0xA5 passes through. Breq drop → grant low the next cycle; readback of 0x0005 by M0 returns 0xA5.
- Both request in the same IDLE cycle after reset → M0 granted. After M0 releases, M1 (still requesting) is granted 3 cycles after M0's breq drop.
- Alternating ties over 4 rounds → grants M0, M1, M0, M1. M1 toggles mX_valid while M0 owns the bus → s_master_valid follows M0 only; m1_slave_ready stays 0.
- TIMEOUT=8, M1 granted then silent with breq high → grant drops after 8 idle cycles; timeout_err high for exactly 1 cycle; bus_busy=0 during TURNAROUND.
- rstn low mid data phase of a write → cycle after reset all outputs 0, state IDLE; a subsequent tie grants M0.
- Read by M1 with mX_ready held low for 20 cycles while s_slave_valid=1, TIMEOUT=8 → no timeout, because slave activity resets idle_cnt.
